// File: rtl/pending_index_encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pending_index_pkg
//  Description : Shared constants, FSM state type and helpers for the
//                pending-index encoder (64-bit mask -> serial 6-bit indices).
//  Revision    : 1.0  initial release
// ============================================================================
package pending_index_pkg;

    localparam int WIDTH = 64;   // request vector width, equals 2**IDX_W
    localparam int IDX_W = 6;    // index width
    localparam int CNT_W = 7;    // emitted-count width, must hold WIDTH

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // One-hot mask selecting bit idx of a WIDTH-bit vector.
    function automatic logic [WIDTH-1:0] bit_mask(input logic [IDX_W-1:0] idx);
        logic [WIDTH-1:0] c_one;
        c_one = {{(WIDTH-1){1'b0}}, 1'b1};
        return c_one << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pending_index_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : pending_index_encoder_if
//  Description : Load / drain handshake bundle of the pending-index encoder.
//                master = producer/consumer side, slave = encoder side.
//  Revision    : 1.0  initial release
// ============================================================================
interface pending_index_encoder_if;
    import pending_index_pkg::*;

    logic             flush;
    logic             load;
    logic [WIDTH-1:0] req_vec;
    logic             load_ready;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_index;
    logic             done;
    logic [CNT_W-1:0] count;

    modport master (
        output flush, load, req_vec, out_ready,
        input  load_ready, out_valid, out_index, done, count
    );

    modport slave (
        input  flush, load, req_vec, out_ready,
        output load_ready, out_valid, out_index, done, count
    );

endinterface
`default_nettype wire

// File: rtl/pending_index_encoder_lsb.sv
`default_nettype none
// ============================================================================
//  Module      : lsb_priority_encoder
//  Description : Combinational lowest-set-bit encoder. idx is 0 when vec is 0;
//                any flags a non-empty vector.
//  Revision    : 1.0  initial release
// ============================================================================
module lsb_priority_encoder
    import pending_index_pkg::*;
#(
    parameter int VEC_W    = WIDTH,
    parameter int IDX_BITS = IDX_W
) (
    input  wire logic [VEC_W-1:0]    vec,
    output logic      [IDX_BITS-1:0] idx,
    output logic                     any
);

    // Scan from the top down so the lowest set bit is the last to win.
    always_comb begin
        idx = '0;
        for (int i = VEC_W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i[IDX_BITS-1:0];
            end
        end
        any = |vec;
    end

endmodule
`default_nettype wire

// File: rtl/pending_index_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : pending_index_encoder
//  Description : Drains a 64-bit request mask one set bit per handshake,
//                presenting the binary index of each set bit in ascending
//                order, with batch count and end-of-batch done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module pending_index_encoder
    import pending_index_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               rst,
    pending_index_encoder_if.slave  bus
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_pending;
    logic [WIDTH-1:0] w_pending_nxt;
    logic [WIDTH-1:0] w_pending_cleared;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic [IDX_W-1:0] w_idx;
    logic             w_any;

    lsb_priority_encoder #(
        .VEC_W    (WIDTH),
        .IDX_BITS (IDX_W)
    ) u_lsb (
        .vec (r_pending),
        .idx (w_idx),
        .any (w_any)
    );

    // State, pending mask, count and done registers; rst beats everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_count   <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_count   <= w_count_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Next-state and output decode; flush outranks load and handshake.
    always_comb begin
        w_state_nxt       = r_state;
        w_pending_nxt     = r_pending;
        w_count_nxt       = r_count;
        w_done_nxt        = 1'b0;
        w_pending_cleared = r_pending & ~bit_mask(w_idx);

        bus.load_ready = (r_state == IDLE);
        bus.out_valid  = (r_state == DRAIN);
        // Index forced to zero outside DRAIN so the bus never shows stale data.
        bus.out_index  = (r_state == DRAIN) ? w_idx : '0;
        bus.done       = r_done;
        bus.count      = r_count;

        if (bus.flush) begin
            w_pending_nxt = '0;
            w_state_nxt   = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.load) begin
                        w_pending_nxt = bus.req_vec;
                        w_count_nxt   = '0;
                        if (bus.req_vec != '0) begin
                            w_state_nxt = DRAIN;
                        end else begin
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.out_ready && w_any) begin
                        w_pending_nxt = w_pending_cleared;
                        w_count_nxt   = r_count + CNT_W'(1);
                        if (w_pending_cleared == '0) begin
                            w_state_nxt = IDLE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pending_index_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pending_index_encoder
//  Description : Directed self-checking bench for pending_index_encoder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pending_index_encoder;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    pending_index_encoder_if bus ();

    pending_index_encoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag, input logic exp_done, input logic [6:0] exp_cnt);
        check({tag, ".valid"}, bus.out_valid, 1'b0);
        check({tag, ".index"}, bus.out_index, 6'd0);
        check({tag, ".lready"}, bus.load_ready, 1'b1);
        check({tag, ".done"}, bus.done, exp_done);
        check({tag, ".count"}, bus.count, exp_cnt);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.load      = 1'b0;
        bus.req_vec   = '0;
        bus.out_ready = 1'b0;

        // Reset
        tick(); tick();
        rst = 1'b0;
        tick();
        check_idle_outputs("reset", 1'b0, 7'd0);

        // Basic drain of 0x29 -> 0, 3, 5
        bus.load = 1'b1; bus.req_vec = 64'h29; bus.out_ready = 1'b1;
        tick();
        bus.load = 1'b0;
        check("basic.v0", bus.out_valid, 1'b1);
        check("basic.i0", bus.out_index, 6'd0);
        check("basic.lr", bus.load_ready, 1'b0);
        tick();
        check("basic.i1", bus.out_index, 6'd3);
        tick();
        check("basic.i2", bus.out_index, 6'd5);
        check("basic.nodone", bus.done, 1'b0);
        tick();
        check_idle_outputs("basic.end", 1'b1, 7'd3);
        tick();
        check("basic.donepulse", bus.done, 1'b0);

        // Backpressure on 0x8000_0000_0000_0001
        bus.load = 1'b1; bus.req_vec = 64'h8000_0000_0000_0001; bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            bus.load = 1'b0;
            check("bp.stall.v", bus.out_valid, 1'b1);
            check("bp.stall.i", bus.out_index, 6'd0);
            check("bp.stall.cnt", bus.count, 7'd0);
        end
        tick();
        bus.out_ready = 1'b1;
        check("bp.i0", bus.out_index, 6'd0);
        tick();
        check("bp.i63", bus.out_index, 6'b111111);
        check("bp.v63", bus.out_valid, 1'b1);
        tick();
        check_idle_outputs("bp.end", 1'b1, 7'd2);

        // Empty load
        tick();
        bus.load = 1'b1; bus.req_vec = '0;
        tick();
        bus.load = 1'b0;
        check_idle_outputs("empty", 1'b1, 7'd0);
        tick();
        check_idle_outputs("empty.after", 1'b0, 7'd0);

        // Full mask with an ignored load mid-drain
        bus.load = 1'b1; bus.req_vec = '1; bus.out_ready = 1'b1;
        for (int k = 0; k < 64; k++) begin
            tick();
            check("full.v", bus.out_valid, 1'b1);
            check("full.i", bus.out_index, 64'(k));
            check("full.cnt", bus.count, 64'(k));
            if (k == 10) begin
                check("full.lready", bus.load_ready, 1'b0);
                bus.load = 1'b1; bus.req_vec = 64'hF;
            end else begin
                bus.load = 1'b0;
            end
        end
        tick();
        check_idle_outputs("full.end", 1'b1, 7'd64);

        // Flush together with load after two accepted indices
        bus.load = 1'b1; bus.req_vec = 64'hFF; bus.out_ready = 1'b1;
        tick();
        bus.load = 1'b0;
        check("flush.i0", bus.out_index, 6'd0);
        tick();
        check("flush.i1", bus.out_index, 6'd1);
        tick();
        check("flush.i2", bus.out_index, 6'd2);
        check("flush.cnt2", bus.count, 7'd2);
        bus.flush = 1'b1; bus.load = 1'b1; bus.req_vec = 64'h3;
        tick();
        bus.flush = 1'b0; bus.load = 1'b0;
        check_idle_outputs("flush", 1'b0, 7'd2);
        tick();
        check_idle_outputs("flush.after", 1'b0, 7'd2);

        // Reset in the middle of a batch
        bus.load = 1'b1; bus.req_vec = 64'hFF;
        tick();
        bus.load = 1'b0;
        check("rst.i0", bus.out_index, 6'd0);
        tick();
        check("rst.i1", bus.out_index, 6'd1);
        check("rst.cnt1", bus.count, 7'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_outputs("rst.mid", 1'b0, 7'd0);
        tick();
        check_idle_outputs("rst.after", 1'b0, 7'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pending_index_encoder.md
Name: pending_index_encoder

Overview:
- Inverse of the 6-to-64 one-hot decoder. Accepts a 64-bit request vector and drains it one set bit per handshake, emitting the 6-bit binary index of each set bit in ascending order.
- Used to serialise multi-bit masks (register-write masks, pending-interrupt bitmaps) back into register/opcode indices for the single-cycle datapath.
- Index encoding matches the decoder: output bit k of the decoder corresponds to index k, and index bit 5 is the MSB (decoder input i1).

Parameters:
- WIDTH, 64, request vector width; must equal 2**IDX_W.
- IDX_W, 6, index width.
- CNT_W, 7, emitted-count width; must hold the value WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- flush  input  1  synchronous abort of the current batch.
- load  input  1  load request; takes effect only when load_ready=1.
- req_vec  input  WIDTH  request mask, sampled on an accepted load.
- load_ready  output  1  high in IDLE only.
- out_valid  output  1  an index is presented on out_index.
- out_ready  input  1  consumer accepts out_index.
- out_index  output  IDX_W  lowest set bit of the pending register.
- done  output  1  single-cycle pulse at the end of a batch.
- count  output  CNT_W  number of indices emitted in the current or last batch.

Behaviour:
- Reset (rst=1 at a clock edge):
  - pending=0, state=IDLE, count=0, done=0.
  - Outputs: out_valid=0, out_index=0, load_ready=1.
  - rst overrides flush and load.
- States:
  - IDLE: load_ready=1, out_valid=0.
  - DRAIN: load_ready=0, out_valid=1.
- IDLE with load=1:
  - pending<=req_vec and count<=0.
  - If req_vec!=0, go to DRAIN. out_valid rises the following cycle, so latency from load to first index is 1 cycle.
  - If req_vec==0, stay in IDLE and pulse done=1 on the next cycle.
- DRAIN:
  - out_index = index of the lowest set bit of pending. It is combinational from the pending register, so it is glitch-free per cycle.
  - It holds stable while out_valid=1 and out_ready=0.
- Handshake (out_valid & out_ready at an edge):
  - Clear pending[out_index] and increment count.
  - If that was the last set bit, go to IDLE and pulse done=1 on the next cycle.
  - Throughput is 1 index per cycle while out_ready is held high.
- load while in DRAIN is ignored. pending and count are unaffected.
- flush=1 (rst=0):
  - pending<=0 and state<=IDLE. count holds its value. No done pulse.
  - flush has priority over both load and a handshake in the same cycle.
- Boundaries:
  - req_vec=all-ones: 64 handshakes, count ends at 64, so no overflow at CNT_W=7.
  - Single bit 63 set: out_index=6'b111111, one handshake.
- out_index is 0 whenever out_valid=0.
- Outputs are never X after the first reset edge.

Decomposition:
- Package pending_index_pkg holds:
  - constants WIDTH, IDX_W, CNT_W;
  - the state enum {IDLE, DRAIN}.
- Sub-module lsb_priority_encoder (combinational):
  - Inputs: vec[WIDTH-1:0].
  - Outputs: idx[IDX_W-1:0], any.
  - idx is the lowest set bit of vec; idx=0 when vec==0.
  - Reusable elsewhere in the datapath.
- Top level holds the pending register, FSM, count and done logic.

Test Plan:
- Reset check: rst=1 for 2 cycles, then released. Expect out_valid=0, load_ready=1, done=0, count=0, out_index=0.
- Basic drain: load req_vec=0x0000_0000_0000_0029 with out_ready=1.
  - Expect out_index 0, then 3, then 5 on consecutive cycles starting 1 cycle after load.
  - Expect done pulse on the cycle after index 5; count=3.
- Backpressure: load 0x8000_0000_0000_0001 with out_ready=0 for 4 cycles.
  - Expect out_index=0 to stay stable with out_valid=1.
  - Then raise out_ready: expect 0, then 63 (6'b111111), done, count=2.
- Empty load: load req_vec=0. Expect no out_valid, done pulse 1 cycle later, count=0, stay in IDLE.
- Full mask and ignored load: load all-ones with out_ready=1.
  - Expect indices 0..63 in order and count=64.
  - A load pulse with req_vec=0xF at cycle 10 of the drain is ignored: the sequence is unaltered and load_ready=0.
- Flush and reset mid-batch:
  - Load 0xFF and accept 2 indices, then assert flush together with load. Expect IDLE next cycle, no done, count=2, and the load discarded.
  - Reload 0xFF and assert rst after 1 handshake. Expect all outputs at reset values next cycle.
